// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between instruction fetch and load/store.
// One transaction in flight; the response strobe fires MEM_LAT cycles after the issue cycle.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [31:0]      ls_addr,
  input  logic [31:0]      ls_wdata,
  input  logic [2:0]       ls_func3,
  output logic             ls_gnt,
  output logic             ls_rvalid,
  output logic [31:0]      ls_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_func3,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  // state    | meaning
  // ST_IDLE  | no transaction in flight, may issue this cycle
  // ST_WAIT  | transaction issued, counting down to the response cycle
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic             owner_q;   // 1 = load/store owns the transaction
  logic             last_q;    // 1 = load/store was granted last
  logic             we_q;
  logic             rdy_q;     // blocks issue until the first edge after reset release
  logic [31:0]      if_rdata_q;
  logic [31:0]      ls_rdata_q;
  logic [CNT_W-1:0] conflict_q;
  logic [CNT_W-1:0] conflict_d;

  logic        issue;
  logic        pick_ls;
  logic        resp;
  logic [31:0] resp_data;

  assign issue   = rdy_q && (state_q == ST_IDLE) && (if_req || ls_req);
  assign pick_ls = ls_req && (!if_req || !last_q);

  assign if_gnt  = issue && !pick_ls;
  assign ls_gnt  = issue && pick_ls;

  assign mem_req   = issue;
  assign mem_we    = ls_gnt && ls_we;
  assign mem_addr  = ls_gnt ? ls_addr  : (if_gnt ? if_addr : 32'd0);
  assign mem_wdata = ls_gnt ? ls_wdata : 32'd0;
  assign mem_func3 = ls_gnt ? ls_func3 : (if_gnt ? 3'd2 : 3'd0);

  assign resp      = (state_q == ST_WAIT) && (cnt_q == 3'd1);
  assign if_rvalid = resp && !owner_q;
  assign ls_rvalid = resp && owner_q;
  assign resp_data = we_q ? 32'd0 : mem_rdata;

  // Read data is live on the response cycle and held afterwards.
  assign if_rdata = if_rvalid ? resp_data : if_rdata_q;
  assign ls_rdata = ls_rvalid ? resp_data : ls_rdata_q;

  always_comb begin
    conflict_d = conflict_q;
    if ((state_q == ST_IDLE) && if_req && ls_req && !(&conflict_q))
      conflict_d = conflict_q + CNT_W'(1);
  end

  assign conflict_cnt = conflict_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      rdy_q      <= 1'b0;
      if_rdata_q <= 32'd0;
      ls_rdata_q <= 32'd0;
      conflict_q <= '0;
    end else begin
      rdy_q      <= 1'b1;
      conflict_q <= conflict_d;
      if (if_rvalid) if_rdata_q <= resp_data;
      if (ls_rvalid) ls_rdata_q <= resp_data;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q <= ST_WAIT;
            cnt_q   <= LAT;
            owner_q <= pick_ls;
            last_q  <= pick_ls;
            we_q    <= pick_ls && ls_we;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default instance plus a MEM_LAT=1, CNT_W=2 instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_func3;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;
  logic [15:0] conflict_cnt;

  logic        b_if_req, b_if_gnt, b_if_rvalid;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid;
  logic [31:0] b_ls_addr, b_ls_wdata, b_ls_rdata;
  logic [2:0]  b_ls_func3;
  logic        b_mem_req, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [2:0]  b_mem_func3;
  logic [1:0]  b_conflict_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_func3(ls_func3),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  mem_arbiter #(.MEM_LAT(1), .CNT_W(2)) u_fast (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_func3(b_ls_func3), .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_func3(b_mem_func3), .mem_rdata(b_mem_rdata), .conflict_cnt(b_conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_func3 = 0;
    mem_rdata = 0;
    b_if_req = 0; b_if_addr = 0; b_ls_req = 0; b_ls_we = 0; b_ls_addr = 0; b_ls_wdata = 0;
    b_ls_func3 = 0; b_mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    if_req = 1; ls_req = 1; if_addr = 32'h55; ls_addr = 32'h66;
    cyc(); #1;
    check("rst_if_gnt", {31'd0, if_gnt}, 0);
    check("rst_ls_gnt", {31'd0, ls_gnt}, 0);
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_conflict", {16'd0, conflict_cnt}, 0);
    check("rst_if_rdata", if_rdata, 0);
    do_reset();

    // Single fetch read, MEM_LAT=2
    cyc(); if_req = 1; if_addr = 32'h100; #1;
    check("t1_if_gnt", {31'd0, if_gnt}, 1);
    check("t1_ls_gnt", {31'd0, ls_gnt}, 0);
    check("t1_mem_req", {31'd0, mem_req}, 1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_we", {31'd0, mem_we}, 0);
    check("t1_mem_func3", {29'd0, mem_func3}, 2);
    cyc(); if_req = 0; if_addr = 0; #1;
    check("t1_wait_mem_req", {31'd0, mem_req}, 0);
    check("t1_wait_mem_addr", mem_addr, 0);
    check("t1_wait_rvalid", {31'd0, if_rvalid}, 0);
    cyc(); mem_rdata = 32'h13; #1;
    check("t1_if_rvalid", {31'd0, if_rvalid}, 1);
    check("t1_if_rdata", if_rdata, 32'h13);
    check("t1_ls_rvalid", {31'd0, ls_rvalid}, 0);
    cyc(); mem_rdata = 32'hFFFF_FFFF; if_req = 1; if_addr = 32'h104; #1;
    check("t1_rvalid_pulse", {31'd0, if_rvalid}, 0);
    check("t1_rdata_hold", if_rdata, 32'h13);
    check("t1_idle_regrant", {31'd0, if_gnt}, 1);

    // Reset one cycle into that second read aborts it
    cyc(); if_req = 0; if_addr = 0; rst = 1'b0; #1;
    check("t4_rst_mem_req", {31'd0, mem_req}, 0);
    check("t4_rst_if_rdata", if_rdata, 0);
    check("t4_rst_if_gnt", {31'd0, if_gnt}, 0);
    cyc(); mem_rdata = 32'hAAAA_AAAA; #1;
    check("t4_no_rvalid", {31'd0, if_rvalid}, 0);
    check("t4_if_rdata_zero", if_rdata, 0);
    cyc(); rst = 1'b1; if_req = 1; ls_req = 1; ls_addr = 32'h300; if_addr = 32'h400; #1;
    check("t4_no_gnt_before_edge", {31'd0, ls_gnt | if_gnt}, 0);
    cyc(); #1;
    check("t4_tie_ls_gnt", {31'd0, ls_gnt}, 1);
    check("t4_tie_if_gnt", {31'd0, if_gnt}, 0);
    check("t4_tie_addr", mem_addr, 32'h300);
    do_reset();

    // Tie from reset: LSU write wins, fetch follows
    cyc();
    if_req = 1; if_addr = 32'h40;
    ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEAD_BEEF; ls_func3 = 3'd2; #1;
    check("t2_ls_gnt", {31'd0, ls_gnt}, 1);
    check("t2_if_gnt", {31'd0, if_gnt}, 0);
    check("t2_mem_we", {31'd0, mem_we}, 1);
    check("t2_mem_addr", mem_addr, 32'h2000);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t2_mem_func3", {29'd0, mem_func3}, 2);
    cyc(); ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_func3 = 0; #1;
    check("t2_no_gnt_in_wait", {31'd0, if_gnt}, 0);
    check("t2_conflict_1", {16'd0, conflict_cnt}, 1);
    cyc(); mem_rdata = 32'h1234_5678; #1;
    check("t2_ls_rvalid", {31'd0, ls_rvalid}, 1);
    check("t2_ls_rdata_write", ls_rdata, 0);
    check("t2_if_rvalid", {31'd0, if_rvalid}, 0);
    cyc(); #1;
    check("t2_if_gnt_t3", {31'd0, if_gnt}, 1);
    check("t2_if_mem_addr", mem_addr, 32'h40);
    check("t2_conflict_still_1", {16'd0, conflict_cnt}, 1);
    cyc(); if_req = 0; if_addr = 0;
    cyc(); #1;
    check("t2_if_rvalid", {31'd0, if_rvalid}, 1);
    check("t2_if_rdata", if_rdata, 32'h1234_5678);
    check("t2_ls_rvalid_quiet", {31'd0, ls_rvalid}, 0);
    do_reset();

    // Both held for six transactions: strict alternation starting with LSU
    cyc(); if_req = 1; ls_req = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t3_ls_gnt_%0d", i), {31'd0, ls_gnt}, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t3_if_gnt_%0d", i), {31'd0, if_gnt}, (i % 2 == 0) ? 0 : 1);
      repeat (3) cyc();
    end
    #1;
    check("t3_conflict_6", {16'd0, conflict_cnt}, 6);
    do_reset();

    // MEM_LAT=1: back-to-back fetches every two cycles
    cyc(); b_if_req = 1;
    for (int i = 0; i < 3; i++) begin
      b_if_addr = 32'h10 * i; #1;
      check($sformatf("t5_gnt_%0d", i), {31'd0, b_if_gnt}, 1);
      check($sformatf("t5_addr_%0d", i), b_mem_addr, 32'h10 * i);
      cyc(); b_mem_rdata = 32'h1000 + i; #1;
      check($sformatf("t5_gap_%0d", i), {31'd0, b_if_gnt}, 0);
      check($sformatf("t5_rvalid_%0d", i), {31'd0, b_if_rvalid}, 1);
      check($sformatf("t5_rdata_%0d", i), b_if_rdata, 32'h1000 + i);
      cyc();
    end
    do_reset();

    // CNT_W=2 conflict counter saturation
    cyc(); b_if_req = 1; b_ls_req = 1;
    repeat (4) cyc(); #1;
    check("t6_conflict_2", {30'd0, b_conflict_cnt}, 2);
    repeat (20) cyc(); #1;
    check("t6_conflict_sat", {30'd0, b_conflict_cnt}, 3);
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 2, meaning cycles from memory issue to mem_rdata valid; legal range 1..4.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the conflict counter.
REQ-003 The block SHALL have port clk  in  1  single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports if_req in 1, if_addr in 32: instruction-fetch read request and word address.
REQ-006 The block SHALL have ports if_gnt out 1, if_rvalid out 1, if_rdata out 32: fetch grant, response strobe and read data.
REQ-007 The block SHALL have ports ls_req in 1, ls_we in 1, ls_addr in 32, ls_wdata in 32, ls_func3 in 3: load/store request, write enable, address, write data and size code (0 b, 1 h, 2 w, 4 ub, 5 uh).
REQ-008 The block SHALL have ports ls_gnt out 1, ls_rvalid out 1, ls_rdata out 32: load/store grant, response strobe and read data.
REQ-009 The block SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_func3 out 3: shared data-memory issue port.
REQ-010 The block SHALL have port mem_rdata in 32: memory read data, valid MEM_LAT cycles after issue.
REQ-011 The block SHALL have port conflict_cnt out CNT_W: number of cycles in which both requests were seen in IDLE.

Function
REQ-012 The FSM SHALL have two states, IDLE and WAIT, and SHALL allow only one transaction in flight.
REQ-013 In IDLE with any request asserted, the block SHALL assert exactly one gnt and mem_req in the same cycle (issue cycle T), driving the winner's fields combinationally onto mem_*.
REQ-014 For a fetch winner, the block SHALL drive mem_we=0 and mem_func3=2.
REQ-015 Requesters SHALL hold req and their fields stable until gnt; the block SHALL never assert gnt while in WAIT.
REQ-016 When only one request is asserted, that requester SHALL win.
REQ-017 When both requests are asserted, the requester not granted last SHALL win; the last-grant pointer SHALL update on every grant.
REQ-018 After reset, the last-grant pointer SHALL equal fetch, so the LSU wins the first tie.
REQ-019 At an issue, the FSM SHALL go IDLE->WAIT, load a latency counter with MEM_LAT, and record the owner.
REQ-020 In WAIT, the latency counter SHALL decrement each cycle.
REQ-021 At T+MEM_LAT, the block SHALL pulse the owner's rvalid for one cycle and return to IDLE.
REQ-022 At the rvalid cycle, the owner's rdata SHALL equal mem_rdata for reads and SHALL be 0 for writes.
REQ-023 The next grant SHALL occur no earlier than T+MEM_LAT+1; a request pending during WAIT SHALL be granted at that cycle.
REQ-024 A non-owner's rvalid SHALL stay 0, and its rdata SHALL hold its last value.
REQ-025 mem_req SHALL be 1 only in issue cycles; mem_* fields SHALL be 0 when mem_req=0.
REQ-026 conflict_cnt SHALL increment when in IDLE and if_req=ls_req=1, and SHALL saturate at all-ones.
REQ-027 Round-robin arbitration SHALL guarantee that a continuously asserted request is granted within two transactions.

Reset
REQ-028 Asserting rst low SHALL immediately force state IDLE, counter 0, pointer=fetch, and conflict_cnt 0.
REQ-029 Asserting rst low SHALL immediately force all gnt, rvalid, and mem_* outputs to 0, and all rdata to 0.
REQ-030 A reset during WAIT SHALL abort the transaction with no rvalid ever produced for it.
REQ-031 The first grant after rst deasserts SHALL occur no earlier than the first clock edge after deassertion.

Verification
REQ-032 MEM_LAT=2, if_req alone, if_addr=0x100 at T, mem_rdata=0x00000013 at T+2 -> if_gnt=mem_req=1 at T, if_rvalid=1 with if_rdata=0x13 at T+2, IDLE at T+3.
REQ-033 if_req and ls_req together from reset, ls_we=1, ls_addr=0x2000, ls_wdata=0xDEADBEEF, ls_func3=2 -> LSU granted at T, mem_we=1, ls_rvalid at T+2 with ls_rdata=0, fetch granted at T+3, conflict_cnt=1.
REQ-034 Both requests held for 6 transactions -> grants alternate LSU, IF, LSU, IF, LSU, IF, with no two consecutive grants to one requester.
REQ-035 rst low at T+1 of a read -> no rvalid at T+2, all outputs 0, next tie grants the LSU.
REQ-036 MEM_LAT=1 with back-to-back fetch requests -> grants every 2 cycles, if_rvalid one cycle after each grant.
REQ-037 CNT_W=2 with conflicts held for 10 IDLE cycles -> conflict_cnt saturates at 3.
